// File: rtl/layer_stream_ctrl.sv
// rtl/layer_stream_ctrl.sv - parallel-to-serial sequencer between two fully-connected layers
//
// Purpose:
//   Latches one layer's parallel output bus in a single cycle and replays the
//   words one per cycle as the serial input stream for the next layer. Reports
//   frame completion, overrun (frame offered while streaming) and misalign
//   (capture with the per-neuron valid bits not all equal).
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   x_in        upstream neuron outputs, word k at x_in[k*DATAWIDTH +: DATAWIDTH]
//   x_in_valid  upstream per-neuron valid bits; bit 0 triggers a capture
//   clr_err     synchronous clear of overrun and misalign
//   out_val     serial word, zero when out_valid is low
//   out_valid   qualifies out_val
//   busy        high while a frame is streaming
//   frame_done  one-cycle pulse after the last word of a frame
//   overrun     sticky, frame arrived while busy (the arriving frame is dropped)
//   misalign    sticky, capture saw unequal valid bits
//   max_idx     (LAYER_STREAM_ARGMAX_EN only) signed argmax of the last frame
//   max_valid   (LAYER_STREAM_ARGMAX_EN only) pulses with frame_done
//
// Optional feature macro: LAYER_STREAM_ARGMAX_EN

module layer_stream_ctrl #(
  parameter int NUM_NEURONS = 10,
  parameter int DATAWIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATAWIDTH*NUM_NEURONS-1:0] x_in,
  input  logic [NUM_NEURONS-1:0]           x_in_valid,
  input  logic                             clr_err,
  output logic [DATAWIDTH-1:0]             out_val,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun,
  output logic                             misalign
`ifdef LAYER_STREAM_ARGMAX_EN
  ,
  output logic [$clog2(NUM_NEURONS)-1:0]   max_idx,
  output logic                             max_valid
`endif
);

  localparam int IW = $clog2(NUM_NEURONS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [DATAWIDTH-1:0] hold_q [NUM_NEURONS];

  logic          capture;
  logic          all_valid;
  logic [IW-1:0] nxt_idx;

  // A new frame is accepted whenever nothing is streaming, including the
  // single DONE cycle, which is what allows back-to-back frames.
  assign capture   = x_in_valid[0] && (state != SEND);
  assign all_valid = &x_in_valid;
  assign nxt_idx   = idx + 1'b1;

`ifdef LAYER_STREAM_ARGMAX_EN
  logic [DATAWIDTH-1:0] run_max;
  logic [IW-1:0]        run_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        hold_q[k] <= '0;
      end
      out_val    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      misalign   <= 1'b0;
`ifdef LAYER_STREAM_ARGMAX_EN
      run_max    <= '0;
      run_idx    <= '0;
      max_idx    <= '0;
      max_valid  <= 1'b0;
`endif
    end else begin
      // Sticky flags: a set event in the same cycle as clr_err wins.
      overrun    <= (overrun & ~clr_err) | (x_in_valid[0] & (state == SEND));
      misalign   <= (misalign & ~clr_err) | (capture & ~all_valid);
      frame_done <= 1'b0;
`ifdef LAYER_STREAM_ARGMAX_EN
      max_valid  <= 1'b0;
`endif

      case (state)
        SEND: begin
          if (idx == LAST_IDX) begin
            state      <= DONE;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_val    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
`ifdef LAYER_STREAM_ARGMAX_EN
            max_idx    <= run_idx;
            max_valid  <= 1'b1;
`endif
          end else begin
            idx     <= nxt_idx;
            out_val <= hold_q[nxt_idx];
`ifdef LAYER_STREAM_ARGMAX_EN
            // Strict greater-than keeps the lower index on ties.
            if ($signed(hold_q[nxt_idx]) > $signed(run_max)) begin
              run_max <= hold_q[nxt_idx];
              run_idx <= nxt_idx;
            end
`endif
          end
        end

        default: begin
          // IDLE, DONE (and the unused encoding) behave alike: capture or idle.
          if (capture) begin
            state <= SEND;
            idx   <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
              hold_q[k] <= x_in[k*DATAWIDTH +: DATAWIDTH];
            end
            // Word 0 is presented straight from the bus so it appears on the
            // cycle right after the capture edge.
            out_val   <= x_in[DATAWIDTH-1:0];
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef LAYER_STREAM_ARGMAX_EN
            run_max   <= x_in[DATAWIDTH-1:0];
            run_idx   <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/layer_stream_ctrl.md
Name: layer_stream_ctrl

Overview:
- Sequencer between two fully-connected layers.
- Captures the parallel output bus of one layer (NUM_NEURONS words plus per-neuron valid bits) in a single cycle.
- Replays the words one per cycle as the serial input_val/input_valid stream that the next layer's neurons consume.
- Reports frame completion and overrun, so layers can be chained without glue logic.

Parameters:
- NUM_NEURONS, 10, number of neurons in the upstream layer, which is also the words per frame (≥2).
- DATAWIDTH, 16, width of each fixed-point word.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- x_in  input  DATAWIDTH*NUM_NEURONS  upstream neuron outputs; word k occupies x_in[k*DATAWIDTH +: DATAWIDTH].
- x_in_valid  input  NUM_NEURONS  upstream per-neuron out_valid bits.
- out_val  output  DATAWIDTH  serial word to the next layer's input_val.
- out_valid  output  1  qualifies out_val; drives the next layer's input_valid.
- busy  output  1  high while a frame is being streamed.
- frame_done  output  1  one-cycle pulse after the last word of a frame.
- overrun  output  1  sticky; a frame arrived while busy.
- misalign  output  1  sticky; a capture saw the valid bits not all equal.
- clr_err  input  1  synchronous clear of overrun and misalign.

Behaviour:
- Reset (async): state=IDLE, index=0, holding register=0. All outputs are 0, including both sticky flags. Asserting rst mid-frame aborts the frame immediately, with no frame_done.
- States: IDLE, SEND, DONE.
- Capture event: x_in_valid[0]=1 at a rising edge while the state is IDLE or DONE.
  - On capture, all NUM_NEURONS words are latched into the holding register, index is set to 0, and the state goes to SEND.
  - If x_in_valid is not all-ones at a capture edge, misalign is set to 1. The frame is still captured and streamed.
- SEND:
  - out_valid=1, out_val=hold[index], busy=1.
  - index increments each cycle.
  - When index=NUM_NEURONS-1, the next state is DONE and index wraps to 0.
- DONE (one cycle): frame_done=1, out_valid=0, busy=0.
  - If a capture event occurs in DONE, the next state is SEND. Otherwise the next state is IDLE.
- Latency: with the capture edge at cycle T, word k appears with out_valid at cycle T+1+k, for k=0..NUM_NEURONS-1. frame_done is high at cycle T+1+NUM_NEURONS.
- Back-to-back frames are separated by exactly one DONE cycle. Minimum frame period is NUM_NEURONS+1 cycles.
- Overrun: x_in_valid[0]=1 during SEND sets overrun=1. The incoming frame is dropped, and the current frame continues unaffected with the holding register unchanged.
- clr_err=1 clears both sticky flags at the next edge. If clr_err coincides with a new setting event, the set wins.
- out_val is 0 whenever out_valid=0. Words are passed through bit-exact; no arithmetic is applied.

Optional Feature:
- Macro: LAYER_STREAM_ARGMAX_EN.
- When defined, two extra outputs are added: max_idx (clog2(NUM_NEURONS) bits) and max_valid (1 bit).
  - A running argmax is computed over the streamed words using a signed compare.
  - On ties, the lower index is kept.
  - max_idx is updated and max_valid pulses together with frame_done. max_idx holds its value until the next frame_done; it resets to 0.
  - Intended for the final classification layer.
- When not defined, these ports and their logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Basic frame: after reset, set x_in words k=0..9 to 0x0100*k and pulse x_in_valid=10'h3FF for 1 cycle at T -> out_valid high for T+1..T+10 with out_val 0x0000, 0x0100, ..., 0x0900 in order; frame_done at T+11; busy low at T+11.
- Back-to-back: apply a second capture pulse exactly in the DONE cycle (T+11) -> second frame streams in T+12..T+21; overrun stays 0.
- Overrun: pulse x_in_valid during T+5 of a frame -> overrun=1 from T+6; remaining words of the first frame are unchanged; no second frame is streamed; clr_err clears overrun.
- Misalign: capture with x_in_valid=10'h1FF -> misalign=1; frame still streams all 10 words.
- Reset mid-frame: assert rst at T+4 -> out_valid, busy and index drop immediately (asynchronously); no frame_done; a fresh frame after release starts at word 0.
- ARGMAX_EN: words {0xFCC2, 0xFF06, 0x0770, 0xFB6C, 0xFE2F, 0xFF13, 0xFB44, 0xF9AF, 0x0770, 0x045C} -> max_idx=2 (tie with index 8 resolves low) and max_valid pulses with frame_done.
